// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, instruction-word layout and FSM states for alu_sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  // Instruction word layout: [12] HALT, [11:9] opcode, [8] SKZ, [7:0] data
  localparam int INSTR_W  = 13;
  localparam int HALT_BIT = 12;
  localparam int OP_MSB   = 11;
  localparam int OP_LSB   = 9;
  localparam int SKZ_BIT  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int OP_W     = OP_MSB - OP_LSB + 1;
  localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_PASS  = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd2;
  localparam logic [OP_W-1:0] OP_AND   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_ABS   = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd6;
  localparam logic [OP_W-1:0] OP_LOADB = 3'd7;

  typedef struct packed {
    logic              halt;
    logic [OP_W-1:0]   op;
    logic              skz;
    logic [DATA_W-1:0] data;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: splits a program word into halt / opcode / skip-if-zero / data fields.
// Latency: combinational.
// Backpressure: none; pure field extraction.
module alu_seq_decode import alu_seq_pkg::*; (
  input  logic [INSTR_W-1:0] word,
  output logic               halt,
  output logic [OP_W-1:0]    op,
  output logic               skz,
  output logic [DATA_W-1:0]  data
);

  assign halt = word[HALT_BIT];
  assign op   = word[OP_MSB:OP_LSB];
  assign skz  = word[SKZ_BIT];
  assign data = word[DATA_MSB:DATA_LSB];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches ROM words, drives the accumulator ALU and writes its result back.
// Latency: 3+ALU_LAT cycles per executed word, 2 per skipped word; done 2 cycles after a HALT fetch.
// Backpressure: none; the ALU has fixed latency. Optional ALU_SEQ_RETIRE_CNT_EN adds the retired counter.
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int AW      = 4,
  parameter int ALU_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               prog_rd,
  output logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  alu_accum,
  output logic [DATA_W-1:0]  alu_data,
  output logic [OP_W-1:0]    alu_opcode,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero,
  output logic [DATA_W-1:0]  acc,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired
`endif
);

  // Wait counter sized to hold ALU_LAT; EXEC ends on its last count.
  localparam int            CW       = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  state_t            state;
  instr_t            ir;
  logic [CW-1:0]     cnt;

  logic              dec_halt;
  logic [OP_W-1:0]   dec_op;
  logic              dec_skz;
  logic [DATA_W-1:0] dec_data;

  // The control flags of ir are consumed straight from the decoder in DECODE.
  logic ir_flags_unused;
  assign ir_flags_unused = ir.halt ^ ir.skz;

  alu_seq_decode u_decode (
    .word (prog_data),
    .halt (dec_halt),
    .op   (dec_op),
    .skz  (dec_skz),
    .data (dec_data)
  );

  assign prog_addr = pc;
  assign alu_accum = acc;
  assign busy      = (state != ST_IDLE);

  // Main sequencer FSM; ALU operands load on the DECODE->EXEC edge so they are
  // stable from the first EXEC cycle through WRITE, and clear again leaving WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= '0;
      acc        <= '0;
      ir         <= '0;
      cnt        <= '0;
      prog_rd    <= 1'b0;
      alu_opcode <= '0;
      alu_data   <= '0;
      done       <= 1'b0;
    end else begin
      prog_rd <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc      <= '0;
            acc     <= '0;
            prog_rd <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          ir <= instr_t'(prog_data);
          if (dec_halt) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (dec_skz && alu_zero) begin
            pc      <= pc + 1'b1;
            prog_rd <= 1'b1;
            state   <= ST_FETCH;
          end else begin
            cnt        <= '0;
            alu_opcode <= dec_op;
            alu_data   <= dec_data;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_opcode <= ir.op;
          alu_data   <= ir.data;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          acc        <= alu_out;
          pc         <= pc + 1'b1;
          alu_opcode <= '0;
          alu_data   <= '0;
          prog_rd    <= 1'b1;
          state      <= ST_FETCH;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  // Count write-backs since the last start, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE && start)) begin
      retired <= '0;
    end else if (state == ST_WRITE && retired != 16'hFFFF) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a 2-cycle ALU model and a synchronous ROM.
// Stimulus pushes expected fetch/done events from a program-level model; a monitor pops them.
// Checks fetch address, accumulator, cycle spacing, done pulse and idle return.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int AW      = 2;
  localparam int ALU_LAT = 2;
  localparam int DEPTH   = 1 << AW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               prog_rd;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data = '0;
  logic [7:0]         alu_accum;
  logic [7:0]         alu_data;
  logic [2:0]         alu_opcode;
  logic [7:0]         alu_out = '0;
  logic               alu_zero;
  logic [7:0]         acc;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               done;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0]        retired;
`endif

  alu_sequencer #(.AW(AW), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_rd    (prog_rd),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .alu_accum  (alu_accum),
    .alu_data   (alu_data),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .acc        (acc),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  always #5 clk = ~clk;

  // Accumulator ALU semantics
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    int x, y, p;
    case (op)
      OP_PASS:  return a;
      OP_ADD:   return a + d;
      OP_SUB:   return a - d;
      OP_AND:   return a & d;
      OP_XOR:   return a ^ d;
      OP_ABS: begin
        x = $signed(a);
        p = (x < 0) ? -x : x;
        return p[7:0];
      end
      OP_MUL: begin
        x = $signed(a[3:0]);
        y = $signed(d[3:0]);
        p = x * y;
        return p[7:0];
      end
      default:  return d;
    endcase
  endfunction

  // ROM and ALU attached to the sequencer
  logic [INSTR_W-1:0] rom [DEPTH];
  logic [7:0]         alu_s1 = '0;
  always @(posedge clk) begin
    if (prog_rd) prog_data <= rom[prog_addr];
    alu_s1  <= alu_f(alu_opcode, alu_accum, alu_data);
    alu_out <= alu_s1;
  end
  assign alu_zero = (alu_accum == 8'h00);

  function automatic logic [INSTR_W-1:0] mk(input bit h, input logic [2:0] op, input bit s, input logic [7:0] d);
    return {h, op, s, d};
  endfunction

  // Scoreboard
  typedef struct {
    bit is_done;
    int addr;
    int acc;
    int gap;
    int ret;
  } ev_t;
  ev_t eq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level reference: walks the ROM and records each fetch and the halt
  task automatic model_run(input int max_fetch, output bit halted);
    int pcm, accm, ret, gap;
    logic [INSTR_W-1:0] w;
    ev_t e;
    pcm = 0; accm = 0; ret = 0; gap = 1; halted = 1'b0;
    for (int n = 0; n < max_fetch; n++) begin
      e = '{0, pcm, accm, gap, 0};
      eq.push_back(e);
      w = rom[pcm];
      if (w[12]) begin
        e = '{1, pcm, accm, 2, ret};
        eq.push_back(e);
        halted = 1'b1;
        return;
      end
      if (w[8] && accm == 0) begin
        gap = 2;
      end else begin
        accm = alu_f(w[11:9], accm[7:0], w[7:0]);
        ret++;
        gap = 3 + ALU_LAT;
      end
      pcm = (pcm + 1) % DEPTH;
    end
  endtask

  // Monitor
  int cyc = 0;
  int last_cyc = 0;
  bit chk_idle = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok_q;
    if (reset) begin
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        chk_idle = 1'b0;
      end
      if (start && !busy) last_cyc = cyc;
      if (prog_rd) begin
        ok_q = (eq.size() > 0) && !eq[0].is_done;
        check("fetch_expected", ok_q, 1);
        if (ok_q) begin
          e = eq.pop_front();
          check("fetch_addr", prog_addr, e.addr);
          check("fetch_pc", pc, e.addr);
          check("fetch_acc", acc, e.acc);
          check("fetch_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
      if (done) begin
        ok_q = (eq.size() > 0) && eq[0].is_done;
        check("done_expected", ok_q, 1);
        if (ok_q) begin
          e = eq.pop_front();
          check("done_acc", acc, e.acc);
          check("done_pc", pc, e.addr);
          check("done_gap", cyc - last_cyc, e.gap);
          check("busy_in_done", busy, 1);
`ifdef ALU_SEQ_RETIRE_CNT_EN
          check("retired", retired, e.ret);
`endif
        end
        chk_idle = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_prog(input int max_fetch);
    bit halted;
    int t;
    model_run(max_fetch, halted);
    pulse_start();
    t = 0;
    while (eq.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("events_drained", eq.size(), 0);
    if (halted) begin
      repeat (3) @(negedge clk);
      check("idle_after_halt", busy, 0);
    end
    if (busy || !halted) begin
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
    end
    eq.delete();
  endtask

  task automatic load4(input logic [12:0] w0, input logic [12:0] w1, input logic [12:0] w2, input logic [12:0] w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit h;
    int t;
    load4('0, '0, '0, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_acc", acc, 0);
    check("rst_pc", pc, 0);
    check("rst_prog_rd", prog_rd, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_data", alu_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Basic program
    load4(mk(0, OP_LOADB, 0, 8'h05), mk(0, OP_ADD, 0, 8'h03), mk(0, OP_SUB, 0, 8'h08), mk(1, 3'd0, 0, 8'h00));
    run_prog(20);
    check("basic_acc", acc, 8'h00);
    check("basic_pc", pc, 3);

    // Skip taken with acc=0
    load4(mk(0, OP_ADD, 1, 8'h01), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00));
    run_prog(20);
    check("skip0_acc", acc, 8'h00);

    // Skip not taken with acc=4
    load4(mk(0, OP_LOADB, 0, 8'h04), mk(0, OP_ADD, 1, 8'h01), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00));
    run_prog(20);
    check("skip4_acc", acc, 8'h05);

    // MUL with nibble sign extension
    load4(mk(0, OP_LOADB, 0, 8'h0F), mk(0, OP_MUL, 0, 8'h03), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00));
    run_prog(20);
    check("mul_acc", acc, 8'hFD);

    // ABS of most-negative value
    load4(mk(0, OP_LOADB, 0, 8'h80), mk(0, OP_ABS, 0, 8'h00), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00));
    run_prog(20);
    check("abs_acc", acc, 8'h80);

    // Wrap-around, no HALT
    load4(mk(0, OP_ADD, 0, 8'h01), mk(0, OP_ADD, 0, 8'h01), mk(0, OP_ADD, 0, 8'h01), mk(0, OP_ADD, 0, 8'h01));
    run_prog(10);

    // Start while busy is ignored
    load4(mk(0, OP_LOADB, 0, 8'h05), mk(0, OP_ADD, 0, 8'h03), mk(0, OP_SUB, 0, 8'h08), mk(1, 3'd0, 0, 8'h00));
    fork
      run_prog(20);
      begin
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join

    // Reset in the middle of EXEC
    load4(mk(0, OP_LOADB, 0, 8'h55), mk(0, OP_ADD, 0, 8'h01), mk(1, 3'd0, 0, 8'h00), mk(1, 3'd0, 0, 8'h00));
    model_run(1, h);
    pulse_start();
    t = 0;
    while (alu_opcode != OP_LOADB && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("exec_reached", alu_opcode, OP_LOADB);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_acc", acc, 0);
    check("midrst_pc", pc, 0);
    check("midrst_opcode", alu_opcode, 0);
    check("midrst_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("midrst_no_write", acc, 0);
    check("midrst_events", eq.size(), 0);
    eq.delete();

    // Randomized programs
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rom[i] = mk($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      end
      run_prog(12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Micro-sequencer that sits directly upstream of the 8-bit accumulator ALU. It fetches instruction words from a synchronous program ROM, decodes them and drives the ALU's accum/data/opcode inputs. After the ALU's fixed latency it writes alu_out back into the accumulator register it owns. It supports skip-if-zero and halt, so short arithmetic programs run without CPU involvement.

Parameters:
AW, 4, program address width (ROM depth 2**AW words)
ALU_LAT, 2, cycles from stable ALU inputs to valid alu_out

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  1-cycle pulse; begins program at address 0
prog_rd  out  1  ROM read strobe
prog_addr  out  AW  ROM address (= pc)
prog_data  in  13  ROM word, valid the cycle after prog_rd
alu_accum  out  8  to ALU accum (= acc register)
alu_data  out  8  to ALU data
alu_opcode  out  3  to ALU opcode
alu_out  in  8  ALU result
alu_zero  in  1  ALU zero flag (accum == 0)
acc  out  8  accumulator register
pc  out  AW  program counter
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse on halt

Behaviour:
- Instruction word: [12] HALT, [11:9] opcode, [8] SKZ, [7:0] data.
- Reset: state IDLE; pc=0, acc=0, ir=0, wait counter=0. prog_rd=0, alu_opcode=0, alu_data=0, busy=0, done=0. Reset mid-program aborts immediately; nothing is written.
- States: IDLE, FETCH, DECODE, EXEC, WRITE, DONE.
- IDLE: on start, pc<=0 and acc<=0, then go to FETCH. start in any other state is ignored.
- FETCH: prog_rd=1, prog_addr=pc, go to DECODE.
- DECODE: ir<=prog_data.
  - HALT=1: go to DONE. pc and acc are unchanged; the other fields are ignored.
  - SKZ=1 and alu_zero=1: pc<=pc+1, go to FETCH (2-cycle skip; ALU not exercised).
  - Otherwise: go to EXEC with counter=0.
- EXEC: alu_opcode=ir[11:9], alu_data=ir[7:0], alu_accum=acc. All three are registered and held stable for all of EXEC and WRITE. Counter increments each cycle; after ALU_LAT cycles go to WRITE.
- WRITE: acc<=alu_out, pc<=pc+1, go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- Outside EXEC/WRITE: alu_opcode=0 and alu_data=0.
- pc wraps modulo 2**AW with no error. A program with no HALT loops forever.
- Timing: a non-skipped instruction takes 3+ALU_LAT cycles (5 at default).
- Accumulator arithmetic is 8-bit, performed entirely in the ALU; the sequencer never modifies alu_out.

Optional Feature:
ALU_SEQ_RETIRE_CNT_EN
- Defined: adds output retired (16 bits). It clears on reset and on start, increments on each WRITE, and saturates at 16'hFFFF. Skipped and HALT words do not count.
- Undefined: the port and the counter are absent.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_PASS=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_XOR=4, OP_ABS=5, OP_MUL=6, OP_LOADB=7
  - instruction field bit positions and width (13)
  - state enum
- Optional sub-module alu_seq_decode: combinational split of the ROM word into halt/op/skz/data.
- The FSM, pc, acc and wait counter stay in alu_sequencer.

Test Plan:
- Basic program: ROM = {LOADB 0x05, ADD 0x03, SUB 0x08, HALT} with a real ALU attached. Required: acc goes 0x05 → 0x08 → 0x00; done pulses once; pc=3; busy low the cycle after done; first WRITE occurs 5 cycles after FETCH.
- Skip taken: with acc=0x00, word {SKZ, ADD 0x01} then HALT. Required: ADD skipped in 2 cycles, acc stays 0x00. With acc=0x04, the same word gives acc=0x05.
- MUL and ABS: LOADB 0x0F, MUL 0x03 → acc=0xFD (−1×3, nibble sign-extend). Separately, LOADB 0x80, ABS → acc=0x80.
- Wrap-around: AW=2, four ADD 0x01 words, no HALT. Required: pc goes 3 → 0 and acc keeps incrementing 0x01, 0x02, … past the fourth instruction.
- Reset mid-EXEC, plus start while busy: reset mid-EXEC returns to IDLE with acc=0, pc=0, alu_opcode=0, and no WRITE. A start pulse while busy is ignored (pc and acc unaffected).
- With ALU_SEQ_RETIRE_CNT_EN defined: running the basic program gives retired=3; the skip test gives retired=0.
